traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter YEL_MIN, default 5: minimum legal yellow duration in cycles.
REQ-002 Parameter GRN_MAX, default 11: maximum legal green duration in cycles; 0 disables the check.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 n_lights, s_lights, e_lights, w_lights  input  3 each  observed lamp drives; 001 green, 010 yellow, 100 red.
REQ-006 override  input  1  high while emergency/jam preemption is active.
REQ-007 clear  input  1  acknowledge; releases a latched fault.
REQ-008 fault  output  1  latched violation flag.
REQ-009 fault_code  output  3  0 none, 1 encoding, 2 conflict, 3 transition, 4 yellow short, 5 green timeout.
REQ-010 fault_dir  output  2  offending direction: N=0, S=1, E=2, W=3.
REQ-011 flash_mode  output  1  request for all-red flash; equals fault.

Function
REQ-012 The FSM SHALL have three states: INIT, RUN and FAULT.
REQ-013 INIT SHALL capture all four lights as the previous sample, load every hold counter with 1, perform no checks, and go to RUN the next cycle.
REQ-014 In RUN, each direction SHALL have a hold counter: +1 per cycle while its light is unchanged, reload to 1 on change, saturating at 31.
REQ-015 An encoding fault SHALL occur when any light is not exactly 001, 010 or 100.
REQ-016 A conflict fault SHALL occur when more than one direction is non-red in the same cycle.
REQ-017 When override is low, a transition fault SHALL occur on green->red, red->yellow or yellow->green; legal changes are green->yellow, yellow->red and red->green.
REQ-018 When override is low, a yellow-short fault SHALL occur on yellow->red with a yellow hold count below YEL_MIN.
REQ-019 When override is low and GRN_MAX>0, a green-timeout fault SHALL occur when a green hold count exceeds GRN_MAX.
REQ-020 While override is high, transition, yellow-short and timeout checks SHALL be suppressed and all hold counters held at 1; encoding and conflict checks SHALL stay active.
REQ-021 On the first cycle after override falls, the previous sample SHALL be the light captured while override was high, and the transition check SHALL apply.
REQ-022 When several faults occur in the same cycle, the lowest fault_code SHALL be reported.
REQ-023 fault_dir SHALL be the lowest-index offending direction; for a conflict, the lowest-index non-red direction.
REQ-024 fault, fault_code, fault_dir and flash_mode SHALL update on the edge that samples the violation (registered, one-cycle latency) and then enter FAULT.
REQ-025 In FAULT, outputs SHALL hold, further violations SHALL be ignored, and clear=1 SHALL zero the outputs and return to INIT.
REQ-026 clear SHALL be ignored in INIT and RUN.
REQ-027 A fault detected in the same cycle that clear is asserted in FAULT SHALL be ignored, because INIT re-baselines.

Reset
REQ-028 When rst=0 at a clock edge, the FSM SHALL go to INIT and fault, fault_code, fault_dir and flash_mode SHALL go to 0, including in mid-operation or in FAULT.
REQ-029 Hold counters and previous samples SHALL be reset to 1 and 100 respectively.

Structure
REQ-030 A shared package SHALL hold the light encodings (GREEN, YELLOW, RED), the fault code constants, the direction indices and the FSM state type.
REQ-031 One sub-module, light_track, SHALL be instantiated four times; each copy holds the previous light and hold counter and outputs per-direction encoding, transition, yellow-short and timeout flags plus non-red.
REQ-032 The top level SHALL hold the FSM, the conflict detection, the priority encoding and the output registers.

Verification
REQ-033 Legal N G(11)->Y(5)->S G sequence through all four directions, override=0 -> fault stays 0 for 64 cycles.
REQ-034 N yellow held 3 cycles, then red -> fault=1, fault_code=4, fault_dir=0, one cycle after the red sample.
REQ-035 e_lights=001 and w_lights=010 in the same cycle -> fault_code=2, fault_dir=2; a later s_lights=011 is ignored until clear.
REQ-036 override=1 with N green->red and S red->green directly -> no fault; the same change with override=0 -> fault_code=3, fault_dir=0.
REQ-037 S green for 12 cycles, override=0 -> fault_code=5, fault_dir=1; then clear=1 -> outputs 0 and INIT, and the next cycle checks nothing.
REQ-038 rst=0 while in FAULT with fault_code=1 -> all outputs 0 at the next edge; w_lights=111 after release -> fault_code=1, fault_dir=3.

Source files
------------

// File: rtl/traffic_light_monitor_pkg.sv
// Shared definitions for the traffic light monitor: lamp encodings, fault codes,
// direction indices, FSM state type and small helper functions.
package traffic_light_monitor_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    localparam logic [2:0] FC_NONE        = 3'd0;
    localparam logic [2:0] FC_ENCODING    = 3'd1;
    localparam logic [2:0] FC_CONFLICT    = 3'd2;
    localparam logic [2:0] FC_TRANSITION  = 3'd3;
    localparam logic [2:0] FC_YEL_SHORT   = 3'd4;
    localparam logic [2:0] FC_GRN_TIMEOUT = 3'd5;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_E = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam int NUM_DIRS = 4;
    localparam int CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_ONE = 5'd1;
    localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Index of the lowest set bit; callers only use it when some bit is set.
    function automatic logic [1:0] lowest_dir(input logic [NUM_DIRS-1:0] v);
        logic [1:0] r;
        r = DIR_N;
        for (int i = NUM_DIRS - 1; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_light_track.sv
// Per-direction tracker: remembers the previous lamp and how long it has been held,
// and flags encoding, transition, yellow-short and green-timeout violations.
module light_track
    import traffic_light_monitor_pkg::*;
#(
    parameter int YEL_MIN = 5,
    parameter int GRN_MAX = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_init,
    input  logic       i_run,
    input  logic       i_override,
    input  logic [2:0] i_light,
    output logic       o_enc_err,
    output logic       o_trans_err,
    output logic       o_yel_short,
    output logic       o_grn_timeout,
    output logic       o_non_red
);

    logic [2:0]       r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_same;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_same     = (i_light == r_prev);
        w_cnt_next = w_same ? sat_inc(r_cnt) : CNT_ONE;

        o_non_red = (i_light != RED);
        o_enc_err = !((i_light == GREEN) || (i_light == YELLOW) || (i_light == RED));

        o_trans_err = !i_override &&
                      (((r_prev == GREEN)  && (i_light == RED))    ||
                       ((r_prev == RED)    && (i_light == YELLOW)) ||
                       ((r_prev == YELLOW) && (i_light == GREEN)));

        // r_cnt is the number of consecutive yellow samples seen before this red one.
        o_yel_short = !i_override && (r_prev == YELLOW) && (i_light == RED) &&
                      (int'(r_cnt) < YEL_MIN);

        // The count including the current sample is what must not exceed the limit.
        o_grn_timeout = !i_override && (GRN_MAX > 0) && (i_light == GREEN) &&
                        (int'(w_cnt_next) > GRN_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev <= RED;
            r_cnt  <= CNT_ONE;
        end else if (i_init) begin
            r_prev <= i_light;
            r_cnt  <= CNT_ONE;
        end else if (i_run) begin
            r_prev <= i_light;
            r_cnt  <= i_override ? CNT_ONE : w_cnt_next;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light safety monitor: watches four lamp drives, latches the first
// violation with its code and direction, and requests all-red flash until cleared.
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int YEL_MIN = 5,
    parameter int GRN_MAX = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] n_lights,
    input  logic [2:0] s_lights,
    input  logic [2:0] e_lights,
    input  logic [2:0] w_lights,
    input  logic       override,
    input  logic       clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic       flash_mode
);

    state_t     r_state;
    logic       r_fault;
    logic [2:0] r_code;
    logic [1:0] r_dir;

    state_t     w_state_next;
    logic       w_fault_next;
    logic [2:0] w_code_next;
    logic [1:0] w_dir_next;

    logic [2:0]          w_light [NUM_DIRS];
    logic [NUM_DIRS-1:0] w_enc;
    logic [NUM_DIRS-1:0] w_trans;
    logic [NUM_DIRS-1:0] w_ysh;
    logic [NUM_DIRS-1:0] w_gto;
    logic [NUM_DIRS-1:0] w_non_red;
    logic                w_conflict;
    logic                w_init;
    logic                w_run;
    logic [2:0]          w_det_code;
    logic [1:0]          w_det_dir;

    assign w_light[DIR_N] = n_lights;
    assign w_light[DIR_S] = s_lights;
    assign w_light[DIR_E] = e_lights;
    assign w_light[DIR_W] = w_lights;

    assign w_init = (r_state == ST_INIT);
    assign w_run  = (r_state == ST_RUN);

    for (genvar g = 0; g < NUM_DIRS; g++) begin : g_track
        light_track #(
            .YEL_MIN(YEL_MIN),
            .GRN_MAX(GRN_MAX)
        ) u_track (
            .clk          (clk),
            .rst          (rst),
            .i_init       (w_init),
            .i_run        (w_run),
            .i_override   (override),
            .i_light      (w_light[g]),
            .o_enc_err    (w_enc[g]),
            .o_trans_err  (w_trans[g]),
            .o_yel_short  (w_ysh[g]),
            .o_grn_timeout(w_gto[g]),
            .o_non_red    (w_non_red[g])
        );
    end

    assign w_conflict = ($countones(w_non_red) > 1);

    // Lowest fault code wins; within a code the lowest-index direction is reported.
    always_comb begin
        w_det_code = FC_NONE;
        w_det_dir  = DIR_N;
        if (|w_enc) begin
            w_det_code = FC_ENCODING;
            w_det_dir  = lowest_dir(w_enc);
        end else if (w_conflict) begin
            w_det_code = FC_CONFLICT;
            w_det_dir  = lowest_dir(w_non_red);
        end else if (|w_trans) begin
            w_det_code = FC_TRANSITION;
            w_det_dir  = lowest_dir(w_trans);
        end else if (|w_ysh) begin
            w_det_code = FC_YEL_SHORT;
            w_det_dir  = lowest_dir(w_ysh);
        end else if (|w_gto) begin
            w_det_code = FC_GRN_TIMEOUT;
            w_det_dir  = lowest_dir(w_gto);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fault_next = r_fault;
        w_code_next  = r_code;
        w_dir_next   = r_dir;
        case (r_state)
            ST_INIT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_det_code != FC_NONE) begin
                    w_state_next = ST_FAULT;
                    w_fault_next = 1'b1;
                    w_code_next  = w_det_code;
                    w_dir_next   = w_det_dir;
                end
            end
            ST_FAULT: begin
                if (clear) begin
                    w_state_next = ST_INIT;
                    w_fault_next = 1'b0;
                    w_code_next  = FC_NONE;
                    w_dir_next   = DIR_N;
                end
            end
            default: begin
                w_state_next = ST_INIT;
                w_fault_next = 1'b0;
                w_code_next  = FC_NONE;
                w_dir_next   = DIR_N;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_fault <= 1'b0;
            r_code  <= FC_NONE;
            r_dir   <= DIR_N;
        end else begin
            r_state <= w_state_next;
            r_fault <= w_fault_next;
            r_code  <= w_code_next;
            r_dir   <= w_dir_next;
        end
    end

    assign fault      = r_fault;
    assign fault_code = r_code;
    assign fault_dir  = r_dir;
    assign flash_mode = r_fault;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios followed by random lamp
// traffic, every cycle compared against a rule-level reference model.
module tb_traffic_light_monitor;

    localparam int YEL_MIN = 5;
    localparam int GRN_MAX = 11;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] lt [4];
    logic       ovr;
    logic       clr;
    logic       fault;
    logic [2:0] code;
    logic [1:0] dir;
    logic       flash;

    int checks = 0;
    int errors = 0;

    // Reference model state: latched outputs, "next edge re-baselines", per-direction history.
    logic       m_fault;
    int         m_code;
    int         m_dir;
    bit         m_base;
    logic [2:0] m_prev [4];
    int         m_len  [4];

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .YEL_MIN(YEL_MIN),
        .GRN_MAX(GRN_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .n_lights  (lt[0]),
        .s_lights  (lt[1]),
        .e_lights  (lt[2]),
        .w_lights  (lt[3]),
        .override  (ovr),
        .clear     (clr),
        .fault     (fault),
        .fault_code(code),
        .fault_dir (dir),
        .flash_mode(flash)
    );

    function automatic bit legal(input logic [2:0] v);
        return (v == G) || (v == Y) || (v == R);
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] v);
        return (v == G) ? Y : (v == Y) ? R : G;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit hit [6][4];
        int nonred;
        int cur;
        bit found;
        if (!rst) begin
            m_fault = 1'b0; m_code = 0; m_dir = 0; m_base = 1'b1;
            for (int d = 0; d < 4; d++) begin m_prev[d] = R; m_len[d] = 1; end
        end else if (m_base) begin
            m_base = 1'b0;
            for (int d = 0; d < 4; d++) begin m_prev[d] = lt[d]; m_len[d] = 1; end
        end else if (m_fault) begin
            if (clr) begin
                m_fault = 1'b0; m_code = 0; m_dir = 0; m_base = 1'b1;
            end
        end else begin
            nonred = 0;
            for (int d = 0; d < 4; d++) if (lt[d] != R) nonred++;
            for (int c = 0; c < 6; c++) for (int d = 0; d < 4; d++) hit[c][d] = 1'b0;
            for (int d = 0; d < 4; d++) begin
                cur = (lt[d] == m_prev[d]) ? ((m_len[d] + 1 > 31) ? 31 : m_len[d] + 1) : 1;
                hit[1][d] = !legal(lt[d]);
                hit[2][d] = (nonred > 1) && (lt[d] != R);
                if (!ovr) begin
                    hit[3][d] = (m_prev[d] == G && lt[d] == R) || (m_prev[d] == R && lt[d] == Y) ||
                                (m_prev[d] == Y && lt[d] == G);
                    hit[4][d] = (m_prev[d] == Y) && (lt[d] == R) && (m_len[d] < YEL_MIN);
                    hit[5][d] = (GRN_MAX > 0) && (lt[d] == G) && (cur > GRN_MAX);
                end
                m_len[d]  = ovr ? 1 : cur;
                m_prev[d] = lt[d];
            end
            found = 1'b0;
            for (int c = 1; c < 6; c++) begin
                for (int d = 0; d < 4; d++) begin
                    if (hit[c][d] && !found) begin
                        found = 1'b1; m_fault = 1'b1; m_code = c; m_dir = d;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_fault", 32'(fault), 32'(m_fault));
        check("model_code", 32'(code), 32'(m_code));
        check("model_dir", 32'(dir), 32'(m_dir));
        check("model_flash", 32'(flash), 32'(m_fault));
    endtask

    task automatic all_red();
        for (int d = 0; d < 4; d++) lt[d] = R;
    endtask

    initial begin
        int act;
        int idx;
        logic [2:0] ph;

        rst = 1'b0; ovr = 1'b0; clr = 1'b0;
        all_red();
        tick(); tick();
        check("reset_fault", 32'(fault), 0);
        check("reset_code", 32'(code), 0);
        rst = 1'b1;
        tick();

        // Legal full cycle through all four directions.
        for (int d = 0; d < 4; d++) begin
            all_red(); lt[d] = G;
            repeat (11) tick();
            lt[d] = Y;
            repeat (5) tick();
        end
        all_red();
        tick();
        check("legal_seq_fault", 32'(fault), 0);

        // Yellow held only three cycles.
        lt[0] = G; repeat (3) tick();
        lt[0] = Y; repeat (3) tick();
        check("ysh_before_red", 32'(fault), 0);
        lt[0] = R; tick();
        check("ysh_fault", 32'(fault), 1);
        check("ysh_code", 32'(code), 4);
        check("ysh_dir", 32'(dir), 0);
        clr = 1'b1; tick();
        check("ysh_cleared", 32'(fault), 0);
        clr = 1'b0; tick();

        // East green with west yellow; later faults ignored while latched.
        lt[2] = G; lt[3] = Y; tick();
        check("conf_code", 32'(code), 2);
        check("conf_dir", 32'(dir), 2);
        lt[1] = 3'b011; tick();
        check("conf_hold_code", 32'(code), 2);
        check("conf_hold_dir", 32'(dir), 2);
        clr = 1'b1; tick();
        check("conf_clear_ignores_fault", 32'(fault), 0);
        clr = 1'b0; all_red(); tick(); tick();
        check("conf_rebased", 32'(fault), 0);

        // Direct green->red under override is tolerated, not without it.
        lt[0] = G; repeat (3) tick();
        ovr = 1'b1; lt[0] = R; lt[1] = G; tick();
        check("ovr_no_fault", 32'(fault), 0);
        repeat (3) tick();
        lt[0] = G; lt[1] = R; tick();
        ovr = 1'b0; lt[0] = R; lt[1] = G; tick();
        check("trans_code", 32'(code), 3);
        check("trans_dir", 32'(dir), 0);
        clr = 1'b1; tick();
        clr = 1'b0; all_red(); tick();

        // South green too long, then clear and an unchecked INIT cycle.
        lt[1] = G; repeat (11) tick();
        check("gto_before", 32'(fault), 0);
        tick();
        check("gto_code", 32'(code), 5);
        check("gto_dir", 32'(dir), 1);
        clr = 1'b1; tick();
        check("gto_clear_fault", 32'(fault), 0);
        check("gto_clear_code", 32'(code), 0);
        clr = 1'b0; all_red(); lt[0] = 3'b111; tick();
        check("init_no_check", 32'(fault), 0);
        lt[0] = R; tick();
        check("after_init", 32'(fault), 0);

        // Reset from FAULT, then encoding fault on west.
        lt[0] = 3'b000; tick();
        check("enc_code_n", 32'(code), 1);
        rst = 1'b0; tick();
        check("rst_fault", 32'(fault), 0);
        check("rst_code", 32'(code), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_flash", 32'(flash), 0);
        rst = 1'b1; all_red(); lt[3] = 3'b111; tick();
        check("enc_init", 32'(fault), 0);
        tick();
        check("enc_code_w", 32'(code), 1);
        check("enc_dir_w", 32'(dir), 3);
        rst = 1'b0; all_red(); tick();
        rst = 1'b1; tick();

        // Random traffic: one active direction cycling, with glitches, override, clear, reset.
        act = 0; ph = R;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                ph = next_phase(ph);
                if (ph == R) act = $urandom_range(0, 3);
            end
            all_red();
            lt[act] = ph;
            if ($urandom_range(0, 31) == 0) begin
                idx = $urandom_range(0, 3);
                lt[idx] = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 24) == 0) ovr = ~ovr;
            clr = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
